// File: rtl/serial_frame_deser_pkg.sv
// Shared types and defaults for the serial frame deserializer.
package serial_frame_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHAN = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_CHAN_W  = 2;
    localparam int unsigned DEF_ERR_W   = 3;
    localparam int unsigned DEF_TIMEOUT = 15;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_frame_deser_shift.sv
// MSB-first left-shift register used to assemble the channel and data fields.
module deser_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: clear wins, otherwise shift the new bit in at the LSB.
    always_comb begin
        q_d = q_q;
        if (clear_i) begin
            q_d = '0;
        end else if (shift_en_i) begin
            q_d = (q_q << 1) | WIDTH'(bit_i);
        end
    end

    // Shift register state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_frame_deser.sv
// Strobed serial frame receiver: start, channel, data, even parity.
// Good frames update data_out/chan_out with a one-cycle out_valid pulse;
// parity errors and mid-frame stalls bump a saturating error counter.
module serial_frame_deser
    import serial_frame_deser_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CHAN_W  = DEF_CHAN_W,
    parameter int unsigned ERR_W   = DEF_ERR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              sin_en,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_out,
    output logic [CHAN_W-1:0] chan_out,
    output logic              out_valid,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(max_u(DATA_W, CHAN_W) + 1);
    localparam int unsigned GAP_W = $clog2(TIMEOUT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               par_q, par_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic [CHAN_W-1:0]  chan_out_q, chan_out_d;
    logic               out_valid_q, out_valid_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic               sr_clear;
    logic               chan_shift;
    logic               data_shift;
    logic               good_frame;
    logic               err_event;
    logic [CHAN_W-1:0]  chan_sr;
    logic [DATA_W-1:0]  data_sr;

    deser_shift #(.WIDTH(CHAN_W)) u_chan_shift (
        .clk_i      (clk),
        .rst_i      (reset),
        .clear_i    (sr_clear),
        .shift_en_i (chan_shift),
        .bit_i      (sin),
        .q_o        (chan_sr)
    );

    deser_shift #(.WIDTH(DATA_W)) u_data_shift (
        .clk_i      (clk),
        .rst_i      (reset),
        .clear_i    (sr_clear),
        .shift_en_i (data_shift),
        .bit_i      (sin),
        .q_o        (data_sr)
    );

    // Frame FSM, bit/gap counters, parity accumulation and output updates.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        par_d       = par_q;
        sr_clear    = 1'b0;
        chan_shift  = 1'b0;
        data_shift  = 1'b0;
        good_frame  = 1'b0;
        err_event   = 1'b0;

        if (state_q == ST_IDLE) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            if (sin_en && sin) begin
                state_d  = ST_CHAN;
                sr_clear = 1'b1;
                par_d    = 1'b0;
            end
        end else if (sin_en) begin
            gap_cnt_d = '0;
            case (state_q)
                ST_CHAN: begin
                    chan_shift = 1'b1;
                    par_d      = par_q ^ sin;
                    if (bit_cnt_q == CNT_W'(CHAN_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    data_shift = 1'b1;
                    par_d      = par_q ^ sin;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_PAR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // Even parity: accumulated ones plus the parity bit must be even.
                    if ((par_q ^ sin) == 1'b0) begin
                        good_frame = 1'b1;
                    end else begin
                        err_event = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            endcase
        end else if (gap_cnt_q == GAP_W'(TIMEOUT - 1)) begin
            state_d   = ST_IDLE;
            gap_cnt_d = '0;
            err_event = 1'b1;
        end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end

        out_valid_d = good_frame;
        data_out_d  = good_frame ? data_sr : data_out_q;
        chan_out_d  = good_frame ? chan_sr : chan_out_q;

        err_cnt_d = err_cnt_q;
        if (clear_err) begin
            err_cnt_d = '0;
        end else if (err_event && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            par_q       <= 1'b0;
            data_out_q  <= '0;
            chan_out_q  <= '0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            par_q       <= par_d;
            data_out_q  <= data_out_d;
            chan_out_q  <= chan_out_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign data_out  = data_out_q;
    assign chan_out  = chan_out_q;
    assign out_valid = out_valid_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_deser.sv
// Self-checking bench for serial_frame_deser: frame table plus corner sequences,
// with a scoreboard of expected good frames checked on each out_valid pulse.
module tb_serial_frame_deser;

    logic       clk = 1'b0;
    logic       reset;
    logic       sin;
    logic       sin_en;
    logic       clear_err;
    logic [7:0] data_out;
    logic [1:0] chan_out;
    logic       out_valid;
    logic [2:0] err_cnt;
    logic       busy;

    serial_frame_deser #(
        .DATA_W  (8),
        .CHAN_W  (2),
        .ERR_W   (3),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_en    (sin_en),
        .clear_err (clear_err),
        .data_out  (data_out),
        .chan_out  (chan_out),
        .out_valid (out_valid),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    typedef struct {
        logic [1:0]  chan;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] data;
        logic       bad;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [1:0]  m_chan;
    logic [7:0]  m_data;
    logic [2:0]  m_err;

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Cycle count used to verify out_valid latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.cyc);
                check("sb_chan_out", 32'(chan_out), 32'(mon_e.chan));
                check("sb_data_out", 32'(data_out), 32'(mon_e.data));
            end
        end
    end

    // One clock cycle with the given strobe/bit applied.
    task automatic drive(input logic en, input logic b);
        sin_en = en;
        sin    = b;
        @(posedge clk);
        #1;
        sin_en = 1'b0;
        sin    = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] ch, input logic [7:0] d, input logic bad,
                              input int stall_after, input int stall_len, input logic clr_at_par);
        logic p;
        p = ^{ch, d};
        if (bad) p = ~p;
        drive(1'b1, 1'b1);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 1; i >= 0; i--) drive(1'b1, ch[i]);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, d[i]);
            if ((8 - i) == stall_after) repeat (stall_len) drive(1'b0, 1'b0);
        end
        if (clr_at_par) clear_err = 1'b1;
        if (!bad) sb.push_back('{ch, d, cyc + 1});
        drive(1'b1, p);
        clear_err = 1'b0;
        if (clr_at_par) m_err = '0;
        else if (bad && m_err != 3'd7) m_err = m_err + 3'd1;
        if (!bad) begin
            m_chan = ch;
            m_data = d;
        end
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err));
        check({tag, "_chan_out"}, 32'(chan_out), 32'(m_chan));
        check({tag, "_data_out"}, 32'(data_out), 32'(m_data));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b10, 8'hA5, 1'b0};
        tbl[1] = '{2'b10, 8'hA5, 1'b1};
        tbl[2] = '{2'b01, 8'h3C, 1'b0};
        tbl[3] = '{2'b00, 8'h00, 1'b0};
        tbl[4] = '{2'b11, 8'hFF, 1'b0};
        tbl[5] = '{2'b11, 8'hFF, 1'b1};
        tbl[6] = '{2'b00, 8'h01, 1'b0};
        tbl[7] = '{2'b01, 8'h80, 1'b1};

        reset = 1'b1; sin = 1'b0; sin_en = 1'b0; clear_err = 1'b0;
        m_chan = '0; m_data = '0; m_err = '0;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_idle_state("rst");

        // Table of good/bad frames, one idle cycle between each.
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].chan, tbl[i].data, tbl[i].bad, -1, 0, 1'b0);
            drive(1'b0, 1'b0);
            check_idle_state("tbl");
        end

        // Saturation of the error counter, then clear.
        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        clear_err = 1'b0;
        m_err = '0;
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send_frame(2'b11, 8'h5A, 1'b1, -1, 0, 1'b0);
            drive(1'b0, 1'b0);
            check("sat_err_cnt", 32'(err_cnt), 32'(m_err));
        end
        check("sat_final", 32'(err_cnt), 32'd7);
        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        clear_err = 1'b0;
        m_err = '0;
        check("sat_clear", 32'(err_cnt), 32'd0);

        // Timeout after the 4th data bit.
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
        repeat (14) drive(1'b0, 1'b0);
        check("to_busy_14", 32'(busy), 32'd1);
        check("to_err_14", 32'(err_cnt), 32'd0);
        drive(1'b0, 1'b0);
        m_err = m_err + 3'd1;
        check("to_busy_15", 32'(busy), 32'd0);
        check("to_err_15", 32'(err_cnt), 32'd1);
        // A 14-cycle stall is tolerated.
        send_frame(2'b01, 8'hC3, 1'b0, 4, 14, 1'b0);
        drive(1'b0, 1'b0);
        check_idle_state("stall14");

        // Reset in the middle of the data field.
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
        reset = 1'b1;
        drive(1'b0, 1'b0);
        reset = 1'b0;
        m_chan = '0; m_data = '0; m_err = '0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check_idle_state("mid_rst");
        send_frame(2'b01, 8'h3C, 1'b0, -1, 0, 1'b0);
        drive(1'b0, 1'b0);
        check_idle_state("post_rst");

        // clear_err wins over a same-cycle parity error.
        send_frame(2'b10, 8'h0F, 1'b1, -1, 0, 1'b0);
        drive(1'b0, 1'b0);
        check("pre_clr_err", 32'(err_cnt), 32'd1);
        send_frame(2'b10, 8'h0F, 1'b1, -1, 0, 1'b1);
        drive(1'b0, 1'b0);
        check("clr_vs_err", 32'(err_cnt), 32'd0);

        // sin=0 strobes while idle do not start a frame.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            check("idle_zero_busy", 32'(busy), 32'd0);
        end

        // Back-to-back frames: second start bit lands in the out_valid cycle.
        send_frame(2'b11, 8'h81, 1'b0, -1, 0, 1'b0);
        send_frame(2'b00, 8'h7E, 1'b0, -1, 0, 1'b0);
        drive(1'b0, 1'b0);
        check_idle_state("b2b");

        repeat (3) drive(1'b0, 1'b0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
